// File: rtl/vga_color_pkg.sv
// Purpose: shared types and palette for the VGA colour sequencer path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_color_pkg;

    localparam int MAX_COLORS = 8;

    typedef enum logic [1:0] {S_MANUAL, S_HOLD, S_AUTO} seq_state_t;

    // Packed as {red[7:0], green[7:0], blue[7:0]}.
    typedef logic [23:0] rgb24_t;

    localparam rgb24_t PALETTE [MAX_COLORS] = '{
        24'h000000,   // black
        24'hFF0000,   // red
        24'h00FF00,   // green
        24'h0000FF,   // blue
        24'hFFFFFF,   // white
        24'hFFFF00,   // yellow
        24'h00FFFF,   // cyan
        24'hFF00FF    // magenta
    };

endpackage

// File: rtl/btn_sync_edge.sv
// Purpose: 2-FF synchroniser plus registered rising-edge detector for a raw button level.
// Latency: pulse is high for one cycle following the 3rd clk edge after btn rises.
// Backpressure: none; a level held high yields exactly one pulse.
//
// Ports: clk, reset (async active-low), btn (raw asynchronous level), pulse (one-cycle).
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;   // previous synchronised level, for edge detection

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
            pulse   <= sync_q2 & ~sync_q3;
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// Purpose: cycles a palette index (manual button step or auto every N frames) and drives registered RGB.
// Latency: index/RGB/wrapped update on the clk edge that samples the qualifying frame_start.
// Backpressure: none; requests during hold are discarded, extra presses within a frame collapse.
//
// Ports: clk, reset (async active-low), advance (raw button), frame_start (vblank pulse),
//        mode (0 manual / 1 auto), dir (0 fwd / 1 back), hold (freeze),
//        color_idx, red/green/blue (COLOR_W each), wrapped (one-cycle wrap pulse).
module color_sequencer
    import vga_color_pkg::*;
#(
    parameter int NUM_COLORS      = 5,
    parameter int COLOR_W         = 8,
    parameter int FRAMES_PER_STEP = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic               frame_start,
    input  logic               mode,
    input  logic               dir,
    input  logic               hold,
    output logic [2:0]         color_idx,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               wrapped
);

    if (NUM_COLORS < 2 || NUM_COLORS > MAX_COLORS) begin : g_bad_num_colors
        $error("color_sequencer: NUM_COLORS must be in 2..8");
    end
    if (FRAMES_PER_STEP < 1) begin : g_bad_frames
        $error("color_sequencer: FRAMES_PER_STEP must be >= 1");
    end

    localparam int                CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [2:0]        LAST_IDX = 3'(NUM_COLORS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    // Top COLOR_W bits of an 8-bit channel; wider outputs repeat the channel
    // bits so full scale stays full scale.
    function automatic logic [COLOR_W-1:0] scale_chan(input logic [7:0] c);
        logic [COLOR_W-1:0] r;
        r = '0;
        for (int i = 0; i < COLOR_W; i++) begin
            r[COLOR_W-1-i] = c[7-(i%8)];
        end
        return r;
    endfunction

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              adv_pulse;
    logic              pending;
    logic              pending_nxt;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  frame_cnt_nxt;
    logic              step;
    logic [2:0]        idx_nxt;
    logic              wrap_nxt;
    rgb24_t            rgb_nxt;

    btn_sync_edge u_adv_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (advance),
        .pulse (adv_pulse)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_MANUAL;
        end else begin
            state <= state_nxt;
        end
    end

    // hold outranks mode; the registered state governs behaviour next cycle.
    always_comb begin
        state_nxt = S_MANUAL;
        if (hold) begin
            state_nxt = S_HOLD;
        end else if (mode) begin
            state_nxt = S_AUTO;
        end
    end

    always_comb begin
        step          = 1'b0;
        pending_nxt   = pending;
        frame_cnt_nxt = frame_cnt;
        unique case (state)
            S_MANUAL: begin
                // A press landing on the frame_start cycle itself still counts.
                if (frame_start && (pending || adv_pulse)) begin
                    step        = 1'b1;
                    pending_nxt = 1'b0;
                end else if (adv_pulse) begin
                    pending_nxt = 1'b1;
                end
            end
            S_AUTO: begin
                pending_nxt = 1'b0;
                if (frame_start) begin
                    if (frame_cnt == CNT_LAST) begin
                        step          = 1'b1;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            default: begin
                pending_nxt = 1'b0;
            end
        endcase
        // Auto mode always starts a fresh frame count and never inherits a press.
        if (state_nxt == S_AUTO && state != S_AUTO) begin
            frame_cnt_nxt = '0;
            pending_nxt   = 1'b0;
        end
    end

    always_comb begin
        idx_nxt  = color_idx;
        wrap_nxt = 1'b0;
        if (step) begin
            if (!dir) begin
                if (color_idx == LAST_IDX) begin
                    idx_nxt  = 3'd0;
                    wrap_nxt = 1'b1;
                end else begin
                    idx_nxt = color_idx + 3'd1;
                end
            end else begin
                if (color_idx == 3'd0) begin
                    idx_nxt  = LAST_IDX;
                    wrap_nxt = 1'b1;
                end else begin
                    idx_nxt = color_idx - 3'd1;
                end
            end
        end
        rgb_nxt = PALETTE[idx_nxt];
    end

    // RGB is looked up from the next index so it moves on the same edge as color_idx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= 1'b0;
            frame_cnt <= '0;
            color_idx <= 3'd0;
            wrapped   <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            pending   <= pending_nxt;
            frame_cnt <= frame_cnt_nxt;
            color_idx <= idx_nxt;
            wrapped   <= wrap_nxt;
            red       <= scale_chan(rgb_nxt[23:16]);
            green     <= scale_chan(rgb_nxt[15:8]);
            blue      <= scale_chan(rgb_nxt[7:0]);
        end
    end

endmodule

// File: tb/tb_color_sequencer.sv
// Purpose: directed table-driven bench for color_sequencer (NUM_COLORS=5, COLOR_W=8, FRAMES_PER_STEP=3).
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_color_sequencer;

    logic       clk;
    logic       reset;
    logic       advance;
    logic       frame_start;
    logic       mode;
    logic       dir;
    logic       hold;
    logic [2:0] color_idx;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       wrapped;

    int n_cmp = 0;
    int n_err = 0;
    logic wrap_seen;
    logic wrap_stuck;

    typedef struct {
        int         presses;
        int         frames;
        logic       mode;
        logic       dir;
        logic       hold;
        logic [2:0] exp_idx;
        logic       exp_wrap;
    } vec_t;

    vec_t tbl [17];
    logic [23:0] ref_pal [8];

    color_sequencer #(
        .NUM_COLORS      (5),
        .COLOR_W         (8),
        .FRAMES_PER_STEP (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .frame_start (frame_start),
        .mode        (mode),
        .dir         (dir),
        .hold        (hold),
        .color_idx   (color_idx),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .wrapped     (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [2:0] exp_idx);
        check({name, " idx"}, {29'd0, color_idx}, {29'd0, exp_idx});
        check({name, " rgb"}, {8'd0, red, green, blue}, {8'd0, ref_pal[exp_idx]});
    endtask

    // Button press long enough for the synchroniser; leaves one pending request.
    task automatic press();
        advance = 1'b1;
        repeat (4) tick();
        advance = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        wrap_seen  = wrap_seen | wrapped;
        frame_start = 1'b0;
        tick();
        wrap_stuck = wrap_stuck | wrapped;
    endtask

    task automatic apply(input int i);
        mode = tbl[i].mode;
        dir  = tbl[i].dir;
        hold = tbl[i].hold;
        tick();
        tick();
        wrap_seen  = 1'b0;
        wrap_stuck = 1'b0;
        repeat (tbl[i].presses) press();
        repeat (tbl[i].frames) frame();
        check_out($sformatf("vec%0d", i), tbl[i].exp_idx);
        check($sformatf("vec%0d wrap", i), {31'd0, wrap_seen}, {31'd0, tbl[i].exp_wrap});
        check($sformatf("vec%0d wrap_width", i), {31'd0, wrap_stuck}, 32'd0);
    endtask

    initial begin
        ref_pal[0] = 24'h000000; ref_pal[1] = 24'hFF0000;
        ref_pal[2] = 24'h00FF00; ref_pal[3] = 24'h0000FF;
        ref_pal[4] = 24'hFFFFFF; ref_pal[5] = 24'hFFFF00;
        ref_pal[6] = 24'h00FFFF; ref_pal[7] = 24'hFF00FF;

        //             presses frames mode dir hold idx wrap
        tbl[0]  = '{1, 1,  1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[1]  = '{1, 1,  1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[2]  = '{1, 1,  1'b0, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[3]  = '{1, 1,  1'b0, 1'b0, 1'b0, 3'd4, 1'b0};
        tbl[4]  = '{1, 1,  1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
        tbl[5]  = '{1, 1,  1'b0, 1'b1, 1'b0, 3'd4, 1'b1};
        tbl[6]  = '{1, 1,  1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
        // auto mode, starting from idx 0 after a reset
        tbl[7]  = '{0, 3,  1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[8]  = '{2, 3,  1'b1, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[9]  = '{0, 3,  1'b1, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[10] = '{0, 2,  1'b1, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[11] = '{4, 10, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[12] = '{0, 2,  1'b1, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[13] = '{0, 1,  1'b1, 1'b0, 1'b0, 3'd4, 1'b0};
        tbl[14] = '{0, 3,  1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
        tbl[15] = '{1, 1,  1'b0, 1'b0, 1'b0, 3'd4, 1'b0};
        tbl[16] = '{1, 1,  1'b0, 1'b0, 1'b0, 3'd0, 1'b1};

        reset = 1'b0; advance = 1'b0; frame_start = 1'b0;
        mode = 1'b0; dir = 1'b0; hold = 1'b0;
        wrap_seen = 1'b0; wrap_stuck = 1'b0;

        // Reset: button wiggles while in reset must not produce a step.
        for (int i = 0; i < 5; i++) begin
            advance = ~advance;
            tick();
        end
        advance = 1'b0;
        tick();
        check_out("reset", 3'd0);
        check("reset wrapped", {31'd0, wrapped}, 32'd0);
        reset = 1'b1;
        repeat (4) tick();
        frame();
        check_out("post_reset_no_step", 3'd0);

        for (int i = 0; i < 7; i++) apply(i);

        // Collapse: three presses in one frame give one step, on the frame_start edge.
        dir = 1'b0;
        tick();
        repeat (3) press();
        check_out("collapse_before_frame", 3'd3);
        frame_start = 1'b1;
        #2;
        check_out("collapse_during_frame", 3'd3);
        tick();
        check_out("collapse_step", 3'd4);
        frame_start = 1'b0;
        tick();
        frame();
        check_out("collapse_single", 3'd4);

        // Pulse latency: frame_start after 2 edges is too early, after 3 edges steps.
        advance = 1'b1;
        tick();
        tick();
        frame_start = 1'b1;
        tick();
        check_out("latency_early", 3'd4);
        tick();
        check_out("latency_step", 3'd0);
        check("latency wrapped", {31'd0, wrapped}, 32'd1);
        frame_start = 1'b0;
        tick();
        check("latency wrapped width", {31'd0, wrapped}, 32'd0);
        frame();
        check_out("level_held_one_pulse", 3'd0);
        advance = 1'b0;
        repeat (4) tick();

        // Reset mid-step with a request pending.
        press();
        frame();
        check_out("pre_midreset", 3'd1);
        press();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_out("midreset_async", 3'd0);
        check("midreset wrapped", {31'd0, wrapped}, 32'd0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        frame();
        check_out("midreset_pending_dropped", 3'd0);

        for (int i = 7; i < 17; i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
- Parametrised colour-cycling sequencer for the VGA path: selects one of NUM_COLORS palette entries and drives registered RGB to the pixel mux.
- Manual mode advances on a button edge; auto mode advances every FRAMES_PER_STEP frames. Direction is selectable and hold freezes the sequence.
- All index changes are applied only on frame_start, so a colour change never tears mid-frame.

Parameters:
- NUM_COLORS, 5, number of palette entries cycled; legal range 2..8.
- COLOR_W, 8, bits per RGB channel output.
- FRAMES_PER_STEP, 60, frames between advances in auto mode; must be >= 1.

Ports:
- clk  input  1  system/pixel clock
- reset  input  1  asynchronous active-low reset
- advance  input  1  raw button level, asynchronous to clk
- frame_start  input  1  one-cycle pulse from the VGA timing generator at start of vertical blank
- mode  input  1  0 = manual step, 1 = auto
- dir  input  1  0 = forward, 1 = backward
- hold  input  1  1 = freeze index, discard requests
- color_idx  output  3  current palette index
- red  output  COLOR_W  red channel of palette[color_idx]
- green  output  COLOR_W  green channel
- blue  output  COLOR_W  blue channel
- wrapped  output  1  one-cycle pulse when the index wraps

Behaviour:
- Reset (reset = 0, asynchronous): state = S_MANUAL, color_idx = 0, RGB = palette[0] = all zero, wrapped = 0, pending = 0, frame counter = 0, synchroniser flops = 0.
- advance input:
  - Passes through a 2-FF synchroniser, then a rising-edge detector.
  - adv_pulse asserts on the 3rd clk edge after advance rises and lasts one cycle.
  - Level held high produces one pulse only.
- FSM states: S_MANUAL, S_AUTO, S_HOLD. Each cycle the next state is taken from inputs with priority hold > mode.
  - hold = 1 -> S_HOLD.
  - else mode = 1 -> S_AUTO.
  - else -> S_MANUAL.
- S_MANUAL:
  - adv_pulse sets pending.
  - On frame_start with pending = 1, or with adv_pulse in the same cycle, the index steps once and pending clears.
  - Multiple pulses within one frame collapse into a single step.
- S_AUTO:
  - adv_pulse is ignored.
  - The frame counter increments on each frame_start.
  - When the counter equals FRAMES_PER_STEP-1 on a frame_start, the index steps and the counter returns to 0.
  - Entering S_AUTO from any other state clears the counter.
  - With FRAMES_PER_STEP = 1, the index steps on every frame_start.
- S_HOLD: index, RGB and counter are frozen; pending is cleared; adv_pulse and frame_start are ignored.
- Step arithmetic:
  - dir = 0: idx = (idx == NUM_COLORS-1) ? 0 : idx+1.
  - dir = 1: idx = (idx == 0) ? NUM_COLORS-1 : idx-1.
  - dir is sampled in the step cycle.
- wrapped: high for exactly the cycle after a step that crossed NUM_COLORS-1 -> 0 (forward) or 0 -> NUM_COLORS-1 (backward); low otherwise.
- RGB timing:
  - RGB is registered from the next index, so red/green/blue and color_idx change on the same clk edge.
  - The index update is visible 1 cycle after the qualifying frame_start.
- Mode change to S_MANUAL keeps any pending flag raised before the switch. Mode change to S_AUTO clears pending.
- Reset asserted mid-frame or mid-step forces all reset values immediately; the first step after deassertion needs a fresh request.
- Elaboration check: NUM_COLORS outside 2..8 or FRAMES_PER_STEP < 1 raises $error.

Decomposition:
- Package vga_color_pkg contains:
  - typedef enum logic [1:0] {S_MANUAL, S_HOLD, S_AUTO} seq_state_t;
  - typedef logic [23:0] rgb24_t;
  - constant PALETTE[8] of rgb24_t: black, red, green, blue, white, yellow, cyan, magenta.
  - MAX_COLORS = 8.
- The COLOR_W output takes the top COLOR_W bits of each 8-bit channel. For COLOR_W > 8, the channel is MSB-replicated.
- One sub-module: btn_sync_edge (2-FF synchroniser plus rising-edge pulse), reusable by other button inputs.

Test Plan:
- Reset: hold reset = 0 for 5 cycles -> color_idx = 0, RGB = 0, wrapped = 0; advance toggled during reset gives no step.
- Manual forward, NUM_COLORS = 5:
  - 3 advance presses, each separated by a frame_start -> color_idx 1, 2, 3; RGB = red, green, blue.
  - 2 further steps -> idx 4 then 0, with a wrapped pulse of exactly 1 cycle.
- Collapse and frame alignment: 3 presses within one frame -> idx unchanged until frame_start, then idx advances by exactly 1, one cycle after frame_start.
- Backward wrap: dir = 1 from idx 0 with one press and one frame_start -> idx = 4 (NUM_COLORS-1), wrapped = 1 for one cycle, RGB = white.
- Auto mode, FRAMES_PER_STEP = 3: 9 frame_start pulses -> steps after frames 3, 6 and 9 (idx 1, 2, 3); advance presses in between have no effect.
- Hold: assert hold after 2 frames in auto, pulse 10 frame_starts and 4 presses -> idx frozen. Release hold -> counter restarts, and the next step occurs 3 frames later.
